// File: rtl/out_ctrl.sv
// Binary-to-BCD display controller: serial double-dabble conversion of a 16-bit value plus a
// multiplexed 4-digit scan driver. Define OUT_ZERO_BLANK_EN to blank leading-zero digits.
module out_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] entrada,
  input  logic        escrever,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  setseg1,
  output logic [3:0]  setseg2,
  output logic [3:0]  setseg3,
  output logic [3:0]  setseg4,
  output logic        estouro,
  output logic [3:0]  anodo,
  output logic [3:0]  digito
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [15:0] latch_q, latch_d;
  logic [19:0] scratch_q, scratch_d;
  logic [3:0]  idx_q, idx_d;
  logic        ocupado_q, ocupado_d;
  logic        pronto_q, pronto_d;
  logic [15:0] seg_q, seg_d;
  logic        estouro_q, estouro_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  dig_q, dig_d;
  logic [3:0]  anodo_q, anodo_d;
  logic [3:0]  digito_q, digito_d;

  logic [19:0] adjusted;
  logic [19:0] shifted;
  logic [1:0]  nextDig;
  logic [3:0]  leadZero;
  logic        unused_entrada_hi;

  assign unused_entrada_hi = ^entrada[31:16];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      latch_q   <= '0;
      scratch_q <= '0;
      idx_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      seg_q     <= '0;
      estouro_q <= 1'b0;
      cnt_q     <= '0;
      dig_q     <= '0;
      anodo_q   <= 4'b1110;
      digito_q  <= '0;
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      scratch_q <= scratch_d;
      idx_q     <= idx_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      seg_q     <= seg_d;
      estouro_q <= estouro_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      anodo_q   <= anodo_d;
      digito_q  <= digito_d;
    end
  end

  // One double-dabble step per cycle; the result is committed from the step using bit 0.
  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q;
    scratch_d = scratch_q;
    idx_d     = idx_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    seg_d     = seg_q;
    estouro_d = estouro_q;
    adjusted  = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted[18:0], latch_q[idx_q]};
    case (state_q)
      IDLE: begin
        if (escrever) begin
          latch_d   = entrada[15:0];
          scratch_d = '0;
          idx_d     = 4'd15;
          ocupado_d = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = shifted;
        idx_d     = idx_q - 4'd1;
        if (idx_q == 4'd0) begin
          seg_d     = shifted[15:0];
          estouro_d = |shifted[19:16];
          pronto_d  = 1'b1;
          ocupado_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan driver: anodo/digito are refreshed only when the divider wraps.
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    dig_d    = dig_q;
    anodo_d  = anodo_q;
    digito_d = digito_q;
    nextDig  = dig_q + 2'd1;
    leadZero = {seg_q[15:12] == 4'd0, seg_q[15:8] == 8'd0, seg_q[15:4] == 12'd0, 1'b0};
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d    = '0;
      dig_d    = nextDig;
      anodo_d  = ~(4'b0001 << nextDig);
      digito_d = seg_q[4*nextDig +: 4];
`ifdef OUT_ZERO_BLANK_EN
      if (leadZero[nextDig]) anodo_d = 4'b1111;
`else
      if (leadZero[nextDig] && 1'b0) anodo_d = 4'b1111;
`endif
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign setseg1 = seg_q[3:0];
  assign setseg2 = seg_q[7:4];
  assign setseg3 = seg_q[11:8];
  assign setseg4 = seg_q[15:12];
  assign estouro = estouro_q;
  assign anodo   = anodo_q;
  assign digito  = digito_q;

endmodule

// File: tb/tb_out_ctrl.sv
// Self-checking bench for out_ctrl: scoreboarded conversions, write/reset corner cases and
// scan sequencing with a short divider; leading-zero blanking is checked when OUT_ZERO_BLANK_EN is set.
module tb_out_ctrl;

  localparam int SCAN = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] entrada;
  logic        escrever;
  logic        ocupado, pronto, estouro;
  logic [3:0]  setseg1, setseg2, setseg3, setseg4, anodo, digito;

  typedef struct packed {
    logic [15:0] digs;
    logic        ov;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] shownDigs = '0;
  logic        shownOv = 1'b0;

  out_ctrl #(.SCAN_DIV(SCAN)) dut (
    .clock(clock), .reset(reset), .entrada(entrada), .escrever(escrever),
    .ocupado(ocupado), .pronto(pronto),
    .setseg1(setseg1), .setseg2(setseg2), .setseg3(setseg3), .setseg4(setseg4),
    .estouro(estouro), .anodo(anodo), .digito(digito)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] v);
    int m;
    exp_t e;
    m = int'(v[15:0]) % 10000;
    e.digs = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    e.ov = (v[15:0] > 16'd9999);
    return e;
  endfunction

  // Drive a write for one edge; optionally record the expected result.
  task automatic startWrite(input logic [31:0] v, input bit push);
    entrada = v;
    escrever = 1'b1;
    tick();
    escrever = 1'b0;
    if (push) sb.push_back(model(v));
    check("accept_ocupado", ocupado, 1);
    check("accept_pronto", pronto, 0);
  endtask

  // Wait for pronto (bounded), checking busy/hold behaviour and the fixed latency.
  task automatic waitResult(input int startCycles);
    int cycles;
    exp_t e;
    cycles = startCycles;
    while (pronto !== 1'b1 && cycles < 40) begin
      check("busy_ocupado", ocupado, 1);
      check("busy_hold_digits", {setseg4, setseg3, setseg2, setseg1}, shownDigs);
      check("busy_hold_estouro", estouro, shownOv);
      tick();
      cycles++;
    end
    check("pronto_seen", pronto, 1);
    check("latency", cycles, 16);
    check("done_ocupado", ocupado, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result_digits", {setseg4, setseg3, setseg2, setseg1}, e.digs);
      check("result_estouro", estouro, e.ov);
      shownDigs = e.digs;
      shownOv = e.ov;
    end else begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed pronto expected no result pending");
    end
  endtask

  // Lock onto the start of the units slot, then check two full scan rounds.
  task automatic scanCheck(input string tag, input logic [15:0] expA, input logic [15:0] expD,
                           input logic [3:0] checkD);
    logic [3:0] prev;
    int n;
    prev = anodo;
    n = 0;
    tick();
    while (!(anodo === 4'b1110 && prev !== 4'b1110) && n < 40) begin
      prev = anodo;
      tick();
      n++;
    end
    check({tag, "_lock"}, (n < 40), 1);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < SCAN; c++) begin
        check({tag, "_anodo"}, anodo, expA[4*(s%4) +: 4]);
        if (checkD[s%4]) check({tag, "_digito"}, digito, expD[4*(s%4) +: 4]);
        tick();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    entrada = '0;
    escrever = 1'b0;
    #12;
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_digits", {setseg4, setseg3, setseg2, setseg1}, 16'h0000);
    check("rst_estouro", estouro, 0);
    check("rst_anodo", anodo, 4'b1110);
    check("rst_digito", digito, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    $display("[TB] conversion of 1234");
    startWrite(32'd1234, 1'b1);
    waitResult(0);
    tick();
    check("pronto_one_cycle", pronto, 0);
    check("hold_after_done", {setseg4, setseg3, setseg2, setseg1}, shownDigs);
    scanCheck("scan1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 16'h1234, 4'b1111);

    $display("[TB] conversion of 65535");
    startWrite(32'd65535, 1'b1);
    waitResult(0);
    tick();

    $display("[TB] 42 with ignored write, then back-to-back 9999");
    startWrite(32'd42, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    entrada = 32'd9999;
    escrever = 1'b1;
    tick();
    escrever = 1'b0;
    check("ignored_write_ocupado", ocupado, 1);
    waitResult(5);
    startWrite(32'd9999, 1'b1);
    waitResult(0);
    tick();

    $display("[TB] reset during conversion of 5000");
    startWrite(32'd5000, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ocupado", ocupado, 0);
    check("midrst_pronto", pronto, 0);
    check("midrst_digits", {setseg4, setseg3, setseg2, setseg1}, 16'h0000);
    check("midrst_estouro", estouro, 0);
    check("midrst_anodo", anodo, 4'b1110);
    check("midrst_digito", digito, 0);
    sb.delete();
    shownDigs = '0;
    shownOv = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("post_rst_no_pronto", pronto, 0);
      check("post_rst_idle", ocupado, 0);
    end

    $display("[TB] conversion of 7 after reset");
    startWrite(32'd7, 1'b1);
    waitResult(0);
`ifdef OUT_ZERO_BLANK_EN
    scanCheck("scan7", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 16'h0007, 4'b0001);
`else
    scanCheck("scan7", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 16'h0007, 4'b1111);
`endif

    $display("[TB] conversion of 0");
    startWrite(32'd0, 1'b1);
    waitResult(0);
`ifdef OUT_ZERO_BLANK_EN
    scanCheck("scan0", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 16'h0000, 4'b0001);
`else
    scanCheck("scan0", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 16'h0000, 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
